// File: rtl/rv32i_divider.sv
// RV32M divide/remainder unit (DIV, DIVU, REM, REMU): radix-2^K restoring shift-subtract.
// Optional macro DIV_EARLY_OUT_EN: operands with |a| < |b| finish in one cycle through the special path.
module rv32i_divider #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_flush,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_div,
  input  logic        i_divu,
  input  logic        i_rem,
  input  logic        i_remu,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_y
);

  localparam int N     = 32 / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SPEC, S_ITER, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        quo_q, quo_d;
  logic [32:0]        rem_q, rem_d;
  logic [31:0]        dvsr_q, dvsr_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               isrem_q, isrem_d;
  logic [31:0]        spec_q, spec_d;
  logic [31:0]        y_q, y_d;
  logic               done_q, done_d;

  function automatic logic [31:0] abs32(input logic is_signed, input logic [31:0] x);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] x);
    return neg ? (~x + 32'd1) : x;
  endfunction

  // K chained restoring steps; quo shifts dividend bits out at the top and quotient bits in at the bottom
  function automatic logic [64:0] iter_step(input logic [32:0] rem,
                                            input logic [31:0] quo,
                                            input logic [31:0] dvsr);
    logic [32:0] r;
    logic [31:0] q;
    logic [32:0] d;
    r = rem;
    q = quo;
    d = {1'b0, dvsr};
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      r = {r[31:0], q[31]};
      q = {q[30:0], 1'b0};
      if (r >= d) begin
        r    = r - d;
        q[0] = 1'b1;
      end
    end
    return {r, q};
  endfunction

  logic        op_any, accept, signed_in, rem_in;
  logic [31:0] a_abs, b_abs;
  logic        b_zero, ovf, early, special;
  logic [31:0] spec_y;
  logic [64:0] step;

  assign op_any    = i_div | i_divu | i_rem | i_remu;
  assign accept    = (state_q == S_IDLE) && i_start && op_any && !i_flush;
  // priority div > divu > rem > remu
  assign signed_in = i_div | (~i_divu & i_rem);
  assign rem_in    = ~i_div & ~i_divu & (i_rem | i_remu);
  assign a_abs     = abs32(signed_in, i_a);
  assign b_abs     = abs32(signed_in, i_b);
  assign b_zero    = (i_b == 32'd0);
  assign ovf       = signed_in && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

`ifdef DIV_EARLY_OUT_EN
  assign early = !b_zero && (a_abs < b_abs);
`else
  assign early = 1'b0;
`endif

  assign special = b_zero || ovf || early;
  assign step    = iter_step(rem_q, quo_q, dvsr_q);

  always_comb begin
    spec_y = rem_in ? i_a : 32'd0;
    if (ovf)    spec_y = rem_in ? 32'd0 : 32'h8000_0000;
    if (b_zero) spec_y = rem_in ? i_a : 32'hFFFF_FFFF;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = special ? S_SPEC : S_ITER;
      S_SPEC: state_d = S_IDLE;
      S_ITER: if (cnt_q == CNT_W'(N - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_flush) state_d = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    isrem_d = isrem_q;
    spec_d  = spec_q;
    y_d     = y_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          quo_d   = a_abs;
          rem_d   = 33'd0;
          dvsr_d  = b_abs;
          qneg_d  = signed_in & (i_a[31] ^ i_b[31]);
          rneg_d  = signed_in & i_a[31];
          isrem_d = rem_in;
          spec_d  = spec_y;
        end
      end
      S_SPEC: begin
        y_d    = spec_q;
        done_d = 1'b1;
      end
      S_ITER: begin
        {rem_d, quo_d} = step;
        cnt_d          = cnt_q + CNT_W'(1);
      end
      S_FIX: begin
        y_d    = isrem_q ? neg_if(rneg_q, rem_q[31:0]) : neg_if(qneg_q, quo_q);
        done_d = 1'b1;
      end
      default: ;
    endcase
    // an aborted op never publishes a result
    if (i_flush) begin
      y_d    = y_q;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      quo_q   <= 32'd0;
      rem_q   <= 33'd0;
      dvsr_q  <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      isrem_q <= 1'b0;
      spec_q  <= 32'd0;
      y_q     <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      isrem_q <= isrem_d;
      spec_q  <= spec_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  assign o_busy = (state_q != S_IDLE);
  assign o_done = done_q;
  assign o_y    = y_q;

endmodule

// File: tb/tb_rv32i_divider.sv
// Self-checking bench for rv32i_divider: arithmetic reference model plus directed hand-computed vectors.
module tb_rv32i_divider;

  localparam int K = 1;
  localparam int N = 32 / K;
`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
  localparam bit EO     = 1'b1;
`else
  localparam int EO_LAT = N + 1;
  localparam bit EO     = 1'b0;
`endif

  logic        clk, rst, start, flush;
  logic [31:0] a, b;
  logic [3:0]  ops;  // {div, divu, rem, remu}
  logic        busy, done;
  logic [31:0] y;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  rv32i_divider #(.BITS_PER_CYCLE(K)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_flush(flush),
    .i_a(a), .i_b(b),
    .i_div(ops[3]), .i_divu(ops[2]), .i_rem(ops[1]), .i_remu(ops[0]),
    .o_busy(busy), .o_done(done), .o_y(y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: results and latency from the arithmetic rules
  function automatic int op_of(input logic [3:0] f);
    if (f[3]) return 0;
    if (f[2]) return 1;
    if (f[1]) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] uabs(input bit sgn, input logic [31:0] x);
    return (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

  function automatic logic [31:0] ref_y(input int op, input logic [31:0] av, input logic [31:0] bv);
    longint sa, sb;
    if (bv == 32'd0) return (op == 0 || op == 1) ? 32'hFFFF_FFFF : av;
    if ((op == 0 || op == 2) && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF)
      return (op == 0) ? 32'h8000_0000 : 32'd0;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (op)
      0: return 32'(sa / sb);
      1: return av / bv;
      2: return 32'(sa % sb);
      default: return av % bv;
    endcase
  endfunction

  function automatic int ref_lat(input int op, input logic [31:0] av, input logic [31:0] bv);
    bit sgn;
    sgn = (op == 0 || op == 2);
    if (bv == 32'd0) return 1;
    if (sgn && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return 1;
    if (EO && (uabs(sgn, av) < uabs(sgn, bv))) return 1;
    return N + 1;
  endfunction

  logic        m_busy, m_done;
  logic [31:0] m_y, m_pend;
  int          m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_y    <= 32'd0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (flush) begin
        m_busy <= 1'b0;
      end else if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_y    <= m_pend;
        end
        m_left <= m_left - 1;
      end else if (start && (ops != 4'd0)) begin
        m_busy <= 1'b1;
        m_left <= ref_lat(op_of(ops), a, b);
        m_pend <= ref_y(op_of(ops), a, b);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("cyc_done", {31'd0, done}, {31'd0, m_done});
      chk("cyc_y", y, m_y);
    end
  end

  task automatic run_op(input logic [3:0] f, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_y, input int exp_lat, input bit now, input string nm);
    int c, bc;
    if (!now) @(negedge clk);
    start = 1'b1; ops = f; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; ops = 4'd0;
    c = 0; bc = 0;
    while (!done && c < 200) begin
      bc += int'(busy);
      @(negedge clk);
      c++;
    end
    chk({nm, "_lat"}, c, exp_lat);
    chk({nm, "_busy_cycles"}, bc, exp_lat);
    chk({nm, "_y"}, y, exp_y);
  endtask

  initial begin
    int c, seen, op;
    logic [3:0]  f;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; flush = 1'b0; ops = 4'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_y", y, 32'd0);
    rst = 1'b0;

    run_op(4'b0100, 32'd100, 32'd7, 32'd14, N + 1, 1'b0, "divu_100_7");
    run_op(4'b0001, 32'd100, 32'd7, 32'd2, N + 1, 1'b0, "remu_100_7");
    run_op(4'b1000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, N + 1, 1'b0, "div_m7_2");
    run_op(4'b0010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, N + 1, 1'b0, "rem_m7_2");
    run_op(4'b1000, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, N + 1, 1'b0, "div_7_m2");
    run_op(4'b0010, 32'd7, 32'hFFFF_FFFE, 32'd1, N + 1, 1'b0, "rem_7_m2");
    run_op(4'b0100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, "divu_5_0");
    run_op(4'b0001, 32'd5, 32'd0, 32'd5, 1, 1'b0, "remu_5_0");
    run_op(4'b1000, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, "div_m1_0");
    run_op(4'b0010, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, 1'b0, "rem_m7_0");
    run_op(4'b1000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, "div_ovf");
    run_op(4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0, "rem_ovf");
    run_op(4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, EO_LAT, 1'b0, "divu_ovf_ops");
    run_op(4'b0100, 32'd3, 32'd10, 32'd0, EO_LAT, 1'b0, "divu_3_10");
    run_op(4'b0001, 32'd3, 32'd10, 32'd3, EO_LAT, 1'b0, "remu_3_10");
    run_op(4'b0010, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, EO_LAT, 1'b0, "rem_m3_10");
    run_op(4'b1010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, N + 1, 1'b0, "prio_div_rem");
    run_op(4'b0011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, N + 1, 1'b0, "prio_rem_remu");
    run_op(4'b0101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, N + 1, 1'b0, "prio_divu_remu");

    // back-to-back: each start lands in the previous op's done cycle
    run_op(4'b0100, 32'd100, 32'd7, 32'd14, N + 1, 1'b0, "b2b_0");
    run_op(4'b0001, 32'd1000, 32'd9, 32'd1, N + 1, 1'b1, "b2b_1");
    run_op(4'b0100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1, "b2b_2");
    run_op(4'b0100, 32'd50, 32'd5, 32'd10, N + 1, 1'b1, "b2b_3");

    @(negedge clk);
    start = 1'b1; ops = 4'd0; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    chk("noflag_busy", {31'd0, busy}, 32'd0);
    chk("noflag_y", y, 32'd10);

    // start while busy must be ignored
    @(negedge clk);
    start = 1'b1; ops = 4'b0100; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; ops = 4'd0;
    c = 0;
    while (!done && c < 200) begin
      if (c == 4) begin start = 1'b1; ops = 4'b1000; a = 32'd1; b = 32'd1; end
      @(negedge clk);
      start = 1'b0; ops = 4'd0;
      c++;
    end
    chk("busy_start_lat", c, N + 1);
    chk("busy_start_y", y, 32'd14);

    // flush in ITER cycle 10
    @(negedge clk);
    start = 1'b1; ops = 4'b0100; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0; ops = 4'd0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); seen += int'(done); end
    chk("flush_no_done", seen, 0);
    chk("flush_y", y, 32'd14);

    // flush beats start in IDLE
    start = 1'b1; flush = 1'b1; ops = 4'b0100; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; ops = 4'd0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);

    // flush in SPEC
    start = 1'b1; ops = 4'b0100; a = 32'd5; b = 32'd0;
    @(negedge clk);
    start = 1'b0; ops = 4'd0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_spec_done", {31'd0, done}, 32'd0);
    chk("flush_spec_y", y, 32'd14);

    // reset mid-ITER
    start = 1'b1; ops = 4'b0100; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; ops = 4'd0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_iter_y", y, 32'd0);
    chk("rst_iter_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 300; i++) begin
      f = 4'b0001 << ($urandom % 4);
      if ($urandom % 8 == 0) f = f | 4'($urandom % 16);
      case ($urandom % 5)
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom; rb = $urandom % 16; end
        2: begin ra = $urandom; rb = 32'd0; end
        3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: begin
          ra = $urandom % 1000; rb = $urandom % 1000;
          if ($urandom % 2) ra = 32'd0 - ra;
          if ($urandom % 2) rb = 32'd0 - rb;
        end
      endcase
      op = op_of(f);
      run_op(f, ra, rb, ref_y(op, ra, rb), ref_lat(op, ra, rb), 1'($urandom % 2), "rnd");
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
